// File: rtl/alu_operand_stage.sv
// Operand/issue stage in front of the 64-bit ALU: 2-entry skid FIFO that captures
// A/B operands with mem/wb forwarding and keeps snooping forwards while ops wait.
module alu_operand_stage #(
    parameter int XLEN = 64,
    parameter int REGW = 5,
    parameter int IMMW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_opcode,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [REGW-1:0] in_rd,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [IMMW-1:0] in_imm,
    input  logic            in_use_imm,

    input  logic            fwd_m_valid,
    input  logic [REGW-1:0] fwd_m_rd,
    input  logic [XLEN-1:0] fwd_m_data,
    input  logic            fwd_w_valid,
    input  logic [REGW-1:0] fwd_w_rd,
    input  logic [XLEN-1:0] fwd_w_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_opcode,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [REGW-1:0] out_rd
);

    typedef struct packed {
        logic [3:0]      opcode;
        logic [REGW-1:0] rd;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic            use_imm;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } entry_t;

    entry_t      ent_q [2];
    entry_t      ent_d [2];
    logic [1:0]  count_q;
    logic        head_q;
    logic        tail_q;
    logic        push;
    logic        pop;

    // Memory stage is younger than writeback, so it wins; x0 is hardwired and never forwarded.
    function automatic logic [XLEN-1:0] fwd(input logic [REGW-1:0] r, input logic [XLEN-1:0] d);
        if (r != '0 && fwd_m_valid && fwd_m_rd == r)
            return fwd_m_data;
        else if (r != '0 && fwd_w_valid && fwd_w_rd == r)
            return fwd_w_data;
        else
            return d;
    endfunction

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        // NOTE: start from the held contents so every path assigns ent_d and no latch is inferred.
        ent_d = ent_q;
        for (int i = 0; i < 2; i++) begin
            if ((count_q == 2'd2 || (count_q == 2'd1 && head_q == 1'(i)))
                && !(pop && head_q == 1'(i))) begin
                ent_d[i].a = fwd(ent_q[i].rs1, ent_q[i].a);
                if (!ent_q[i].use_imm)
                    ent_d[i].b = fwd(ent_q[i].rs2, ent_q[i].b);
            end
        end
        // The tail slot is never live while a push is possible, so it cannot collide with the snoop.
        if (push) begin
            ent_d[tail_q].opcode  = in_opcode;
            ent_d[tail_q].rd      = in_rd;
            ent_d[tail_q].rs1     = in_rs1;
            ent_d[tail_q].rs2     = in_rs2;
            ent_d[tail_q].use_imm = in_use_imm;
            ent_d[tail_q].a       = fwd(in_rs1, in_rs1_data);
            ent_d[tail_q].b       = in_use_imm ? {{(XLEN-IMMW){in_imm[IMMW-1]}}, in_imm}
                                               : fwd(in_rs2, in_rs2_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            // NOTE: entries are cleared on reset/flush because the outputs must read 0 until the next push.
            for (int i = 0; i < 2; i++)
                ent_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            ent_q <= ent_d;
            if (push)
                tail_q <= ~tail_q;
            if (pop)
                head_q <= ~head_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_opcode = ent_q[head_q].opcode;
    assign out_a      = ent_q[head_q].a;
    assign out_b      = ent_q[head_q].b;
    assign out_rd     = ent_q[head_q].rd;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the 64-bit ALU.
- Accepts decoded ALU micro-ops, selects the A and B operands, and resolves RAW hazards by forwarding from the memory and writeback stages.
- Buffers up to two ops in a skid FIFO with valid/ready handshakes on both sides.
- Its registered opcode/A/B outputs drive the ALU inputs directly.

Parameters:
- XLEN, 64, operand width.
- REGW, 5, register index width.
- IMMW, 12, immediate width (sign-extended to XLEN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all buffered ops.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept an op.
- in_opcode  in  4  ALU opcode (1011 SLT, 1100 SLTU, 1101 SLL, 1110 SRL, 1111 SRA, others pass through).
- in_rs1, in_rs2, in_rd  in  REGW each  source and destination register indices.
- in_rs1_data, in_rs2_data  in  XLEN each  register-file read data.
- in_imm  in  IMMW  immediate.
- in_use_imm  in  1  B operand = sext(in_imm) instead of rs2.
- fwd_m_valid, fwd_m_rd, fwd_m_data  in  1/REGW/XLEN  memory-stage result (younger, higher priority).
- fwd_w_valid, fwd_w_rd, fwd_w_data  in  1/REGW/XLEN  writeback result (older).
- out_valid  out  1  head op valid.
- out_ready  in  1  ALU stage accepts the head op.
- out_opcode  out  4  head opcode.
- out_a, out_b  out  XLEN each  head operands.
- out_rd  out  REGW  head destination register.

Behaviour:
- Storage: 2-entry FIFO. Each entry holds opcode, rd, rs1, rs2, use_imm, A, B. A 2-bit count, 1-bit head pointer and 1-bit tail pointer wrap modulo 2.
- Handshakes:
  - in_ready = (count < 2), driven combinationally from registered state only.
  - Push on in_valid && in_ready; pop on out_valid && out_ready; out_valid = (count != 0).
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, in_ready = 0 and any in_valid is ignored.
- Capture forwarding, applied to a pushed op:
  - A = fwd(rs1, in_rs1_data).
  - B = sext(in_imm) if in_use_imm, else fwd(rs2, in_rs2_data).
  - fwd(r, d) = fwd_m_data if fwd_m_valid && fwd_m_rd == r && r != 0; else fwd_w_data if fwd_w_valid && fwd_w_rd == r && r != 0; else d.
  - Register 0 is never forwarded; it always takes the read data.
- Snoop forwarding, applied every cycle to every valid entry not being popped that cycle:
  - A is replaced by the same fwd() rule on the entry's rs1.
  - B is replaced likewise on the entry's rs2, unless use_imm is set.
  - out_a/out_b may therefore change while out_valid && !out_ready. The consumer samples only on handshake.
- Latency: 1 cycle from push to out_valid for an empty FIFO. No combinational path from in_* to out_*. Throughput is 1 op/cycle when out_ready is held high.
- Shift opcodes: B is passed at full width; the ALU masks B[5:0]. No masking in this stage.
- Outputs: out_opcode, out_a, out_b and out_rd present the head entry. After reset or flush they are 0 until the next push.
- Reset: count = 0, pointers = 0, all entries zeroed; out_valid = 0, in_ready = 1 on the first cycle after reset.
- Flush: takes effect at the next edge; count and pointers = 0, entries zeroed.
  - A push or pop coincident with flush is discarded.
  - rst has priority over flush.
  - Reset or flush mid-stall drops held ops with no output handshake.

Test Plan:
- Reset, then push {opcode=0000, rs1=1, rs2=2, rd=3, rs1_data=5, rs2_data=7}, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7, out_rd=3; the following cycle out_valid=0.
- Push rs1=4 with fwd_m {valid, rd=4, data=0xAA} and fwd_w {valid, rd=4, data=0xBB} -> out_a=0xAA. Repeat with rs1=0 and both forwards targeting rd=0 -> out_a=in_rs1_data.
- out_ready=0, push 2 ops -> in_ready=0 after the second push, a third in_valid is ignored. Raise out_ready -> ops emerge in order, with in_ready returning to 1 after the first pop.
- Stalled head with rs2=9, use_imm=0; pulse fwd_w {rd=9, data=0x1234} for one cycle -> out_b=0x1234 and holds after the pulse. Same with use_imm=1, in_imm=0xFFF -> out_b=0xFFFF_FFFF_FFFF_FFFF, unchanged by the snoop.
- Opcode 1111, use_imm=1, in_imm=0x03F -> out_opcode=1111, out_b=0x3F, unmasked.
- Fill 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, outputs 0. Assert rst while full -> identical result.
